// File: rtl/macguffin_pkg.sv
// +----------------------------------------------------------------------+
// | macguffin_pkg                                                        |
// | Shared widths and FSM state type for the MacGuffin core arbiter.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package macguffin_pkg;

  localparam int DATA_W = 64;
  localparam int KEY_W  = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mgf_rr_pick.sv
// +----------------------------------------------------------------------+
// | mgf_rr_pick                                                          |
// | Rotating-priority picker: first asserted valid at or above rr_ptr,   |
// | wrapping modulo N_REQ.                                               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mgf_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             hit
);

  int unsigned      idx;
  logic [N_REQ-1:0] shifted;

  // Scan from rr_ptr upward; the first requester found keeps the grant.
  always_comb begin
    grant   = '0;
    hit     = 1'b0;
    idx     = 0;
    shifted = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx     = (32'(rr_ptr) + i) % N_REQ;
      shifted = valid >> idx;
      if (!hit && shifted[0]) begin
        hit   = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/macguffin_arbiter.sv
// +----------------------------------------------------------------------+
// | macguffin_arbiter                                                    |
// | Shares one iterative MacGuffin core between N_REQ AXI-Stream         |
// | requesters, round-robin, one block in flight. Optional watchdog      |
// | enabled by defining MGF_ARB_TIMEOUT_EN.                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module macguffin_arbiter
  import macguffin_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0][KEY_W-1:0]    key,
  input  logic [N_REQ-1:0][DATA_W-1:0]   s_axis_tdata,
  input  logic [N_REQ-1:0]               s_axis_tvalid,
  output logic [N_REQ-1:0]               s_axis_tready,
  output logic [N_REQ-1:0][DATA_W-1:0]   m_axis_tdata,
  output logic [N_REQ-1:0]               m_axis_tvalid,
  input  logic [N_REQ-1:0]               m_axis_tready,
  output logic [KEY_W-1:0]               core_key,
  output logic [DATA_W-1:0]              core_s_tdata,
  output logic                           core_s_tvalid,
  input  logic                           core_s_tready,
  input  logic [DATA_W-1:0]              core_m_tdata,
  input  logic                           core_m_tvalid,
  output logic                           core_m_tready,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  res_q, res_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_hit;
  logic               accept;
  logic               tmo_hit;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(N_REQ - 1)) return '0;
    else                        return g + 1'b1;
  endfunction

  mgf_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid  (s_axis_tvalid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_idx),
    .hit    (pick_hit)
  );

  // The picked requester is ready in the same cycle, so a hit in IDLE is a handshake.
  assign accept = (state_q == IDLE) && pick_hit && !rst;

`ifdef MGF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Watchdog expires when the limit is reached and the core is not completing a handshake now.
  always_comb begin
    tmo_hit = (((state_q == ISSUE) && !core_s_tready) ||
               ((state_q == WAIT)  && !core_m_tvalid)) &&
              (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q | tmo_hit;
    if (accept) cnt_d = '0;
    else if ((state_q == ISSUE) || (state_q == WAIT)) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cyc;

  assign tmo_hit            = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
`endif

  // Next-state logic for the arbitration FSM and its holding registers.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    key_d      = key_q;
    data_d     = data_q;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = pick_idx;
          key_d      = key[pick_idx];
          data_d     = s_axis_tdata[pick_idx];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_hit) begin
          rr_ptr_d = next_ptr(grant_id_q);
          state_d  = IDLE;
        end else if (core_s_tready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tmo_hit) begin
          rr_ptr_d = next_ptr(grant_id_q);
          state_d  = IDLE;
        end else if (core_m_tvalid) begin
          res_d   = core_m_tdata;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (m_axis_tready[grant_id_q]) begin
          rr_ptr_d = next_ptr(grant_id_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      key_q      <= '0;
      data_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      key_q      <= key_d;
      data_q     <= data_d;
      res_q      <= res_d;
    end
  end

  // Requester-side handshake signals: at most one lane active at a time.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = '0;
    m_axis_tdata  = '0;
    if (accept) s_axis_tready[pick_idx] = 1'b1;
    if (state_q == DELIVER) begin
      m_axis_tvalid[grant_id_q] = 1'b1;
      m_axis_tdata[grant_id_q]  = res_q;
    end
  end

  assign core_key      = key_q;
  assign core_s_tdata  = data_q;
  assign core_s_tvalid = (state_q == ISSUE);
  assign core_m_tready = (state_q == WAIT);
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_macguffin_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_macguffin_arbiter                                                 |
// | Directed bench with a stub core (result = data ^ key[63:0], 34-cycle |
// | latency) and a scoreboard of expected per-port results. Timeout      |
// | steps are built only when MGF_ARB_TIMEOUT_EN is defined.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_macguffin_arbiter;

  localparam int N   = 2;
  localparam int LAT = 34;
  localparam int TMO = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][127:0]  key;
  logic [N-1:0][63:0]   s_tdata;
  logic [N-1:0]         s_tvalid;
  logic [N-1:0]         s_tready;
  logic [N-1:0][63:0]   m_tdata;
  logic [N-1:0]         m_tvalid;
  logic [N-1:0]         m_tready;
  logic [127:0]         core_key;
  logic [63:0]          core_s_tdata;
  logic                 core_s_tvalid;
  logic                 core_s_tready;
  logic [63:0]          core_m_tdata;
  logic                 core_m_tvalid;
  logic                 core_m_tready;
  logic [0:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  always #5 clk = ~clk;

  macguffin_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .core_key      (core_key),
    .core_s_tdata  (core_s_tdata),
    .core_s_tvalid (core_s_tvalid),
    .core_s_tready (core_s_tready),
    .core_m_tdata  (core_m_tdata),
    .core_m_tvalid (core_m_tvalid),
    .core_m_tready (core_m_tready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  // Stub core: always ready, answers LAT cycles after accepting unless silenced.
  int          stub_cnt;
  logic [63:0] stub_pend;
  logic        stub_silent;

  assign core_s_tready = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      stub_cnt      <= 0;
      stub_pend     <= '0;
      core_m_tvalid <= 1'b0;
      core_m_tdata  <= '0;
    end else begin
      if (core_m_tvalid && core_m_tready) core_m_tvalid <= 1'b0;
      if (core_s_tvalid && core_s_tready) begin
        stub_cnt  <= LAT;
        stub_pend <= core_s_tdata ^ core_key[63:0];
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end else if (stub_cnt == 1) begin
        stub_cnt <= 0;
        if (!stub_silent) begin
          core_m_tvalid <= 1'b1;
          core_m_tdata  <= stub_pend;
        end
      end
    end
  end

  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push expected result on input handshake, compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (s_tvalid[i] && s_tready[i])
          sb.push_back('{i, s_tdata[i] ^ key[i][63:0]});
      if ((m_tvalid & m_tready) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", m_tvalid, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_port_vec", m_tvalid, 2'b01 << mon_e.port);
          chk("out_grant_id", grant_id, mon_e.port);
          chk("out_data", m_tdata[mon_e.port], mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int idx);
    idx = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((s_tvalid & s_tready) != '0) begin
        idx = s_tready[1] ? 1 : 0;
        break;
      end
    end
    total++;
    assert (idx >= 0) else begin
      bad++;
      $error("FAIL accept_wait observed=no_handshake expected=handshake");
    end
    tick();
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s observed=busy=%0b pending=%0d expected=idle,0", tag, busy, sb.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int          idx;
    int          lat;
    int          seen;
    int          cnt0;
    int          cnt1;
    int          order[4];
    logic [127:0] k1;
    logic [63:0]  exp1;

    order       = '{0, 1, 0, 1};
    rst         = 1'b1;
    key         = '0;
    s_tdata     = '0;
    s_tvalid    = '0;
    m_tready    = '1;
    stub_silent = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_core_s_tvalid", core_s_tvalid, 0);
    chk("rst_core_m_tready", core_m_tready, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single block from requester 0
    key[0]     = {64'h0, 64'hFFFF_0000_FFFF_0000};
    s_tdata[0] = 64'h0123_4567_89AB_CDEF;
    s_tvalid[0] = 1'b1;
    wait_accept(idx);
    s_tvalid[0] = 1'b0;
    chk("single_grant", idx, 0);
    chk("single_busy", busy, 1);
    lat = 0;
    while (!m_tvalid[0] && lat < 200) begin
      tick();
      lat++;
    end
    chk("single_latency", lat, 2 + LAT);
    chk("single_data", m_tdata[0], 64'hFEDC_4567_7654_CDEF);
    chk("single_m1_silent", m_tvalid[1], 0);
    wait_idle("single_drain");

    // Round-robin with both requesters valid from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    key[0]     = {$urandom, $urandom, $urandom, $urandom};
    key[1]     = {$urandom, $urandom, $urandom, $urandom};
    s_tdata[0] = {$urandom, $urandom};
    s_tdata[1] = {$urandom, $urandom};
    s_tvalid   = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(idx);
      chk($sformatf("rr_grant%0d", k), idx, order[k]);
      if (idx == 0) begin
        cnt0++;
        s_tdata[0] = {$urandom, $urandom};
        if (cnt0 == 2) s_tvalid[0] = 1'b0;
      end else if (idx == 1) begin
        cnt1++;
        s_tdata[1] = {$urandom, $urandom};
        if (cnt1 == 2) s_tvalid[1] = 1'b0;
      end
    end
    s_tvalid = '0;
    wait_idle("rr_drain");

    // Key changes after accept must not reach the core or the result
    k1          = {$urandom, $urandom, $urandom, $urandom};
    key[0]      = k1;
    s_tdata[0]  = {$urandom, $urandom};
    s_tvalid[0] = 1'b1;
    wait_accept(idx);
    s_tvalid[0] = 1'b0;
    for (int n = 0; n < 10 && !core_m_tready; n++) tick();
    key[0] = ~k1;
    tick();
    chk("core_key_latched", core_key, k1);
    chk("key_wait_state", core_m_tready, 1);
    wait_idle("key_drain");

    // Back-pressure on requester 1 output stalls the arbiter
    m_tready[1] = 1'b0;
    key[1]      = {$urandom, $urandom, $urandom, $urandom};
    s_tdata[1]  = {$urandom, $urandom};
    s_tvalid[1] = 1'b1;
    wait_accept(idx);
    s_tvalid[1] = 1'b0;
    exp1 = s_tdata[1] ^ key[1][63:0];
    for (int n = 0; n < 100 && !m_tvalid[1]; n++) tick();
    s_tdata[0]  = {$urandom, $urandom};
    s_tvalid[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("bp_valid", m_tvalid, 2'b10);
      chk("bp_data", m_tdata[1], exp1);
      chk("bp_no_ready", s_tready, 0);
      chk("bp_no_issue", core_s_tvalid, 0);
    end
    m_tready[1] = 1'b1;
    wait_accept(idx);
    s_tvalid[0] = 1'b0;
    chk("bp_next_grant", idx, 0);
    wait_idle("bp_drain");

    // Reset pulse while waiting on the core
    s_tdata[1]  = {$urandom, $urandom};
    s_tvalid[1] = 1'b1;
    wait_accept(idx);
    s_tvalid[1] = 1'b0;
    for (int n = 0; n < 10 && !core_m_tready; n++) tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("rstw_m_tvalid", m_tvalid, 0);
    chk("rstw_s_tready", s_tready, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_core_s_tvalid", core_s_tvalid, 0);
    chk("rstw_core_m_tready", core_m_tready, 0);
    chk("rstw_grant_id", grant_id, 0);
    seen = 0;
    repeat (60) begin
      tick();
      if (m_tvalid != '0) seen++;
    end
    chk("rstw_no_output", seen, 0);
    s_tdata[0] = {$urandom, $urandom};
    s_tdata[1] = {$urandom, $urandom};
    s_tvalid   = 2'b11;
    wait_accept(idx);
    s_tvalid   = '0;
    chk("rstw_next_grant", idx, 0);
    wait_idle("rstw_drain");

`ifdef MGF_ARB_TIMEOUT_EN
    // Core never answers: watchdog fires, block dropped, arbiter recovers
    stub_silent = 1'b1;
    s_tdata[0]  = {$urandom, $urandom};
    s_tvalid[0] = 1'b1;
    wait_accept(idx);
    s_tvalid[0] = 1'b0;
    lat = 0;
    while (!timeout_err && lat < 200) begin
      tick();
      lat++;
    end
    chk("tmo_cycle", lat, TMO);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_output", m_tvalid, 0);
    sb.delete();
    stub_silent = 1'b0;
    s_tdata[0]  = {$urandom, $urandom};
    s_tvalid[0] = 1'b1;
    wait_accept(idx);
    s_tvalid[0] = 1'b0;
    chk("tmo_next_grant", idx, 0);
    wait_idle("tmo_drain");
    chk("tmo_sticky", timeout_err, 1);
`else
    chk("timeout_tied0", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
